ext_bus_arbiter: RTL
====================

Name: ext_bus_arbiter

Overview:
Two-master arbiter for the external memory-mapped bus, the 0xC000–0xFFFF window.
- Master 0 is the CPU external port. Master 1 is a secondary bus master (DMA/debug).
- The arbiter grants one master at a time and drives a single shared slave bus with a variable-latency ready handshake.
- Each master gets a registered read-data/ack response.
- Sits between the CPU top level and the external peripheral decode.

Parameters:
ADDR_W, 16, address width of masters and slave bus
DATA_W, 16, data width
TIMEOUT_CYC, 255, max cycles waiting on slave_rdy before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m0_req  in  1  master 0 request, held until m0_ack
m0_we  in  1  master 0 write (1) / read (0)
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_ack  out  1  one-cycle completion pulse to master 0
m0_rdata  out  DATA_W  read data for master 0, valid with m0_ack
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  —  same as m0_*, for master 1
slave_re  out  1  shared bus read strobe
slave_we  out  1  shared bus write strobe
slave_addr  out  ADDR_W  shared bus address
slave_wdata  out  DATA_W  shared bus write data
slave_rdata  in  DATA_W  slave read data, valid when slave_rdy=1
slave_rdy  in  1  slave completion
busy  out  1  high in any state other than IDLE
err  out  1  one-cycle timeout pulse (ARB_TIMEOUT_EN only, else tied 0)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state = IDLE; all strobes, acks and err = 0.
  - m0_rdata, m1_rdata, slave_addr, slave_wdata = 0.
  - Round-robin pointer `last` = 1, so master 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, choose a winner:
    - Only one requesting: that one wins.
    - Both requesting: the master not equal to `last` wins.
  - Latch the winner's we, addr and wdata into the slave_* registers; set `last` = winner; go to ACCESS.
  - slave_re/slave_we assert on the next cycle, i.e. 1 cycle after req is sampled.
- ACCESS:
  - slave_re = ~we_l and slave_we = we_l, held constant until slave_rdy is sampled high.
  - On slave_rdy: drop the strobes next cycle; capture slave_rdata into the winner's rdata register on reads only; go to RESP.
  - slave_rdy in the same cycle the strobe first rises is legal (0-wait slave).
- RESP:
  - Winner's ack = 1 for exactly this cycle; go to IDLE.
  - Minimum transaction: req → ack in 3 cycles.
- Master rules:
  - A master must hold req and its payload stable until ack.
  - The arbiter samples the payload only in IDLE.
  - Dropping req mid-transaction is ignored; the transaction completes and ack still pulses.
- Back-to-back:
  - Both masters requesting continuously → strict alternation, 0,1,0,1…
  - One master alone gets consecutive grants; IDLE lasts one cycle between them.
- No-request cycles: slave_rdy outside ACCESS is ignored.
- Reset mid-ACCESS: state returns to IDLE; strobes drop; no ack is issued.
- m*_rdata holds its last read value; writes leave it unchanged.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - An 8+ bit counter (width from clog2(TIMEOUT_CYC+1)) clears on entry to ACCESS and increments each ACCESS cycle without slave_rdy.
  - On reaching TIMEOUT_CYC: abort; drop the strobes; load the winner's rdata with 16'hDEAD (reads only); pulse err with the RESP ack.
  - slave_rdy in the same cycle as the timeout wins; it is a normal completion.
- Undefined: no counter; ACCESS waits indefinitely; err tied to 0.

Decomposition:
- Shared package ext_bus_pkg:
  - state enum {IDLE, ACCESS, RESP}.
  - EXT_BASE = 16'hC000.
  - TIMEOUT_DATA = 16'hDEAD.
- One natural sub-module: rr_arb2, a two-request round-robin picker.
  - Inputs: req[1:0], last. Outputs: gnt[1:0] (one-hot), winner.
  - Purely combinational; the `last` register stays in the parent.

Test Plan:
- Single read: m0 read at 0xC004, slave_rdy one cycle after slave_re with slave_rdata=0x1234 → slave_addr=0xC004; m0_ack pulses with m0_rdata=0x1234; m1_ack stays 0.
- Zero-wait write: m1 write of 0xBEEF to 0xC010, slave_rdy=1 immediately → slave_we high for 1 cycle; m1_ack 3 cycles after req; m1_rdata unchanged.
- Contention: m0 and m1 request continuously, 4 transactions each → grants alternate 0,1,0,1,…; no ack overlap; busy low only 1 cycle between transactions.
- Stretched slave: slave_rdy held low 10 cycles → strobe and addr stable throughout; ack exactly 1 cycle; only one ack per request.
- Reset mid-ACCESS: rst asserted during wait → next cycle strobes=0, state IDLE, no ack; a new m0 request afterwards is granted first.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYC=8): slave_rdy never asserted on an m0 read → abort after 8 ACCESS cycles; m0_rdata=0xDEAD; err and m0_ack pulse together.

Source files
------------

// File: rtl/ext_bus_pkg.sv
// Shared types and constants for the external bus arbiter (0xC000-0xFFFF window).
package ext_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [15:0] EXT_BASE     = 16'hC000;
  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin picker, purely combinational; on a tie the master that was not `last` wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       winner
);

  always_comb begin
    winner = req[1];
    if (req == 2'b11) winner = ~last;
    gnt = 2'b00;
    if (req != 2'b00) gnt = winner ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/ext_bus_arbiter.sv
// Two-master arbiter onto the shared external slave bus; req->ack in 3 cycles minimum, stalls on slave_rdy.
// ARB_TIMEOUT_EN adds an abort after TIMEOUT_CYC wait cycles, returning TIMEOUT_DATA on reads and pulsing err.
module ext_bus_arbiter
  import ext_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              slave_re,
  output logic              slave_we,
  output logic [ADDR_W-1:0] slave_addr,
  output logic [DATA_W-1:0] slave_wdata,
  input  logic [DATA_W-1:0] slave_rdata,
  input  logic              slave_rdy,
  output logic              busy,
  output logic              err
);

  state_t state, next_state;
  logic [1:0] gnt;
  logic winner, last, sel, we_l;
  logic timeout_hit, done;
  logic [DATA_W-1:0] rdata_in;

  rr_arb2 u_rr_arb2 (
    .req    ({m1_req, m0_req}),
    .last   (last),
    .gnt    (gnt),
    .winner (winner)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_CLOG = $clog2(TIMEOUT_CYC + 1);
  localparam int CNT_W    = (CNT_CLOG > 8) ? CNT_CLOG : 8;

  logic [CNT_W-1:0] to_cnt;
  logic to_flag;

  // A slave_rdy landing on the final wait cycle is a normal completion.
  assign timeout_hit = (state == ACCESS) && !slave_rdy &&
                       (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign rdata_in    = timeout_hit ? DATA_W'(TIMEOUT_DATA) : slave_rdata;
  assign err         = (state == RESP) && to_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (state == IDLE) to_cnt <= '0;
      else if (state == ACCESS && !slave_rdy) to_cnt <= to_cnt + 1'b1;
      if (state == ACCESS) to_flag <= timeout_hit;
    end
  end
`else
  logic unused_cfg;

  assign unused_cfg  = (TIMEOUT_CYC != 0);
  assign timeout_hit = 1'b0;
  assign rdata_in    = slave_rdata;
  assign err         = 1'b0;
`endif

  assign done = (state == ACCESS) && (slave_rdy || timeout_hit);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (|gnt) next_state = ACCESS;
      ACCESS:  if (done) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    slave_re = 1'b0;
    slave_we = 1'b0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    busy     = (state != IDLE);
    case (state)
      ACCESS: begin
        slave_re = ~we_l;
        slave_we = we_l;
      end
      RESP: begin
        m0_ack = ~sel;
        m1_ack = sel;
      end
      default: ;
    endcase
  end

  // Payload is sampled only in IDLE, so masters may drop or change req mid-transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      last        <= 1'b1;
      sel         <= 1'b0;
      we_l        <= 1'b0;
      slave_addr  <= '0;
      slave_wdata <= '0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
    end else begin
      if (state == IDLE && (|gnt)) begin
        sel         <= winner;
        last        <= winner;
        we_l        <= winner ? m1_we    : m0_we;
        slave_addr  <= winner ? m1_addr  : m0_addr;
        slave_wdata <= winner ? m1_wdata : m0_wdata;
      end
      if (done && !we_l) begin
        if (sel) m1_rdata <= rdata_in;
        else     m0_rdata <= rdata_in;
      end
    end
  end

endmodule
